// File: rtl/mem_responder.sv
// mem_responder: single-port word memory slave for the LC-3 MAR/MDR path.
// One access per mem_en strobe, fixed completion latency, registered one-cycle
// ready/oob pulse, and read data held until the next read completes.
module mem_responder #(
  parameter int AW_INT  = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_rw,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        oob
);

  localparam int         DEPTH    = 1 << AW_INT;
  localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_LOW
  } state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        rw_q;
  logic [15:0] rdata_q;
  logic        ready_q;
  logic        oob_q;

  logic [15:0] mem [DEPTH];

  // Access operands and the single-cycle "perform access now" strobe.
  logic              do_access;
  logic [15:0]       acc_addr;
  logic [15:0]       acc_wdata;
  logic              acc_rw;
  logic              in_range;
  logic [AW_INT-1:0] acc_idx;

  // Select live inputs for an immediate access, latched ones once BUSY.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    acc_addr  = addr;
    acc_wdata = wdata;
    acc_rw    = mem_rw;
    if (state_q == BUSY) begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_rw    = rw_q;
    end
    do_access = ((state_q == IDLE) && mem_en && (LATENCY == 1)) ||
                ((state_q == BUSY) && (cnt_q == 3'd1));
    in_range  = (acc_addr[15:AW_INT] == '0);
    acc_idx   = acc_addr[AW_INT-1:0];
  end

  // Array write port; reset still blocks a write landing on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch so it maps onto plain RAM; contents are undefined until written.
    if (!rst && do_access && acc_rw && in_range) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  // Request FSM with registered read data and completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rw_q    <= 1'b0;
      rdata_q <= 16'h0000;
      ready_q <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every update sees pre-edge values.
      ready_q <= do_access;
      oob_q   <= do_access && !in_range;
      if (do_access && !acc_rw) begin
        rdata_q <= in_range ? mem[acc_idx] : 16'h0000;
      end

      case (state_q)
        IDLE: begin
          if (mem_en) begin
            if (LATENCY == 1) begin
              state_q <= WAIT_LOW;
            end else begin
              addr_q  <= addr;
              wdata_q <= wdata;
              rw_q    <= mem_rw;
              cnt_q   <= CNT_LOAD;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!mem_en) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign oob   = oob_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 1, 4, 3) with a shared
// reference memory model and a scoreboard of expected completions.
module tb_mem_responder;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [NDUT];
  logic        mem_en [NDUT];
  logic        mem_rw [NDUT];
  logic [15:0] addr   [NDUT];
  logic [15:0] wdata  [NDUT];
  logic [15:0] rdata  [NDUT];
  logic        ready  [NDUT];
  logic        oob    [NDUT];

  mem_responder #(.AW_INT(10), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst[0]), .mem_en(mem_en[0]), .mem_rw(mem_rw[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .oob(oob[0])
  );
  mem_responder #(.AW_INT(10), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst[1]), .mem_en(mem_en[1]), .mem_rw(mem_rw[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .oob(oob[1])
  );
  mem_responder #(.AW_INT(10), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst[2]), .mem_en(mem_en[2]), .mem_rw(mem_rw[2]),
    .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]), .oob(oob[2])
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          d;
    logic [15:0] rdata;
    logic        oob;
  } sb_t;
  sb_t sb_q[$];

  logic [15:0] ref_mem    [NDUT][1024];
  logic [15:0] last_rdata [NDUT];

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 4;
      default: return 3;
    endcase
  endfunction

  // One request: predict, drive, hold mem_en for `hold` edges, watch the pulse.
  task automatic access(input int d, input logic rw, input logic [15:0] a,
                        input logic [15:0] wd, input int hold, input bit perturb);
    sb_t e;
    int  pulses;
    int  lat;
    bit  inr;
    lat    = lat_of(d);
    pulses = 0;
    inr    = (a[15:10] == 6'd0);
    e.d    = d;
    e.oob  = !inr;
    if (rw) begin
      e.rdata = last_rdata[d];
      if (inr) ref_mem[d][a[9:0]] = wd;
    end else begin
      e.rdata       = inr ? ref_mem[d][a[9:0]] : 16'h0000;
      last_rdata[d] = e.rdata;
    end
    sb_q.push_back(e);

    @(negedge clk);
    mem_en[d] = 1'b1;
    mem_rw[d] = rw;
    addr[d]   = a;
    wdata[d]  = wd;
    for (int k = 1; k <= hold + lat + 2; k++) begin
      @(negedge clk);
      if (ready[d] === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          e = sb_q.pop_front();
          checks++;
          if (k != lat) begin
            errors++;
            $display("FAIL latency d=%0d addr=%h: ready after %0d edges, want %0d", d, a, k, lat);
          end
          checks++;
          if (rdata[e.d] !== e.rdata) begin
            errors++;
            $display("FAIL rdata d=%0d addr=%h rw=%b: got %h want %h", d, a, rw, rdata[e.d], e.rdata);
          end
          checks++;
          if (oob[e.d] !== e.oob) begin
            errors++;
            $display("FAIL oob d=%0d addr=%h: got %b want %b", d, a, oob[e.d], e.oob);
          end
        end
      end
      if (k >= hold) mem_en[d] = 1'b0;
      if (perturb) begin
        addr[d]  = a + 16'd1;
        wdata[d] = wd + 16'(k);
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL pulse_count d=%0d addr=%h: got %0d ready pulses want 1", d, a, pulses);
      if (pulses == 0) e = sb_q.pop_front();
    end
  endtask

  task automatic check_idle_outputs(input int d, input string name);
    checks++;
    if (rdata[d] !== 16'h0000 || ready[d] !== 1'b0 || oob[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s d=%0d: rdata=%h ready=%b oob=%b want 0000/0/0",
               name, d, rdata[d], ready[d], oob[d]);
    end
  endtask

  task automatic expect_no_ready(input int d, input int cycles, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (ready[d] !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s d=%0d: got %0d ready cycles want 0", name, d, seen);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; mem_en[d] = 1'b0; mem_rw[d] = 1'b0;
      addr[d] = 16'h0000; wdata[d] = 16'h0000; last_rdata[d] = 16'h0000;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) check_idle_outputs(d, "reset_values");
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) check_idle_outputs(d, "after_reset_release");
  endtask

  task automatic test_write_read();
    access(0, 1'b1, 16'h0003, 16'hBEEF, 2, 1'b0);
    access(0, 1'b0, 16'h0003, 16'h0000, 1, 1'b0);
  endtask

  task automatic test_latency();
    access(1, 1'b1, 16'h0010, 16'h1234, 1, 1'b0);
    access(1, 1'b1, 16'h0011, 16'h5678, 1, 1'b0);
    access(1, 1'b0, 16'h0010, 16'h0000, 1, 1'b1);
    access(1, 1'b0, 16'h0011, 16'h0000, 1, 1'b0);
  endtask

  task automatic test_held_strobe();
    access(0, 1'b1, 16'h0020, 16'h1111, 6, 1'b1);
    access(0, 1'b0, 16'h0020, 16'h0000, 1, 1'b0);
    access(0, 1'b0, 16'h0021, 16'h0000, 1, 1'b0);
    access(1, 1'b1, 16'h0020, 16'h2222, 6, 1'b1);
    access(1, 1'b0, 16'h0020, 16'h0000, 1, 1'b0);
  endtask

  task automatic test_out_of_range();
    access(0, 1'b1, 16'h0000, 16'hAAAA, 1, 1'b0);
    access(0, 1'b1, 16'h0400, 16'h5555, 1, 1'b0);
    access(0, 1'b0, 16'h0400, 16'h0000, 1, 1'b0);
    access(0, 1'b0, 16'h0000, 16'h0000, 1, 1'b0);
    access(0, 1'b0, 16'hFC03, 16'h0000, 1, 1'b0);
    access(0, 1'b0, 16'h0003, 16'h0000, 1, 1'b0);
  endtask

  // Reset sampled one edge after acceptance, then on the would-be access edge.
  task automatic test_reset_busy();
    access(2, 1'b1, 16'h0005, 16'h0001, 1, 1'b0);
    access(2, 1'b0, 16'h0005, 16'h0000, 1, 1'b0);
    for (int rst_k = 1; rst_k <= 2; rst_k++) begin
      @(negedge clk);
      mem_en[2] = 1'b1; mem_rw[2] = 1'b1; addr[2] = 16'h0005; wdata[2] = 16'h7777;
      for (int k = 1; k <= rst_k; k++) begin
        @(negedge clk);
        mem_en[2] = 1'b0;
        checks++;
        if (ready[2] !== 1'b0) begin
          errors++;
          $display("FAIL busy_no_ready k=%0d: got ready=%b want 0", k, ready[2]);
        end
      end
      rst[2] = 1'b1;
      @(negedge clk);
      check_idle_outputs(2, "reset_mid_busy");
      rst[2] = 1'b0;
      last_rdata[2] = 16'h0000;
      expect_no_ready(2, 5, "abandoned_access");
    end
    access(2, 1'b0, 16'h0005, 16'h0000, 1, 1'b0);
  endtask

  // Reset during WAIT_LOW with the strobe still high re-accepts afterwards.
  task automatic test_reset_wait_low();
    @(negedge clk);
    mem_en[0] = 1'b1; mem_rw[0] = 1'b0; addr[0] = 16'h0003;
    @(negedge clk);
    checks++;
    if (ready[0] !== 1'b1 || rdata[0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL wait_low_read: ready=%b rdata=%h want 1/beef", ready[0], rdata[0]);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    check_idle_outputs(0, "reset_in_wait_low");
    rst[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ready[0] !== 1'b1 || rdata[0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL reaccept_after_reset: ready=%b rdata=%h want 1/beef", ready[0], rdata[0]);
    end
    mem_en[0] = 1'b0;
    last_rdata[0] = 16'hBEEF;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [4];
    addrs[0] = 16'h0000; addrs[1] = 16'h03FF; addrs[2] = 16'h0001; addrs[3] = 16'h03FE;
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 4; i++) access(d, 1'b1, addrs[i], 16'($urandom), 1, 1'b0);
      for (int i = 3; i >= 0; i--) access(d, 1'b0, addrs[i], 16'h0000, 1, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_latency();
    test_held_strobe();
    test_out_of_range();
    test_reset_busy();
    test_reset_wait_low();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
